// File: rtl/memory_stage_unit_if.sv
// memory_stage_unit_if
//   Data-memory bus between the memory stage and a variable-latency data memory.
//   Handshake: the stage holds mem_req high with a stable address, data and write
//   flag until the memory returns a one-cycle mem_ack. mem_rdata is only
//   meaningful in the ack cycle.
// Ports (signals):
//   mem_req   stage -> memory  request
//   mem_we    stage -> memory  1 = write, 0 = read
//   mem_addr  stage -> memory  16-bit address
//   mem_wdata stage -> memory  16-bit store data
//   mem_rdata memory -> stage  16-bit load data
//   mem_ack   memory -> stage  completion pulse
interface memory_stage_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/memory_stage_unit.sv
// memory_stage_unit
//   Memory stage of the pipeline. Consumes the execute/memory (XM) register,
//   performs loads/stores over the req/ack data-memory bus, owns the
//   memory/writeback (MW) register and freezes upstream with stall while an
//   access is outstanding. Store data is forwarded from the MW writeback value.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   *_xm                 XM register fields (controls, write_reg, rt, alu_out,
//                        reg2, next_pc)
//   mem                  data-memory bus (master side)
//   stall                combinational upstream freeze
//   *_mw                 MW register contents
//   wb_data              combinational writeback value selected from MW fields
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | accept XM instruction; memory op latches request and stalls
// ACCESS | mem_req held with stable addr/data until mem_ack
// DONE   | retire the memory op into MW, release stall
module memory_stage_unit (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mem_read_xm,
  input  logic                       mem_write_xm,
  input  logic                       mem_to_reg_xm,
  input  logic                       reg_write_xm,
  input  logic                       pcs_xm,
  input  logic                       hlt_xm,
  input  logic [3:0]                 write_reg_xm,
  input  logic [3:0]                 rt_xm,
  input  logic [15:0]                alu_out_xm,
  input  logic [15:0]                reg2_xm,
  input  logic [15:0]                next_pc_xm,
  memory_stage_unit_if.master        mem,
  output logic                       stall,
  output logic                       reg_write_mw,
  output logic                       mem_to_reg_mw,
  output logic                       pcs_mw,
  output logic                       hlt_mw,
  output logic [3:0]                 write_reg_mw,
  output logic [15:0]                alu_out_mw,
  output logic [15:0]                read_data_mw,
  output logic [15:0]                next_pc_mw,
  output logic [15:0]                wb_data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state_q, state_d;

  logic        mem_op;
  logic        we_q;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic [15:0] load_buf_q;
  logic        fwd_hit;
  logic [15:0] fwd_data;

  logic        latch_req;
  logic        capture_mw;
  logic        bubble_mw;
  logic        take_load;
  logic        retire_mem;

  assign mem_op = mem_read_xm | mem_write_xm;

  // Register 0 is never a real producer, so a MW write to it must not forward.
  assign fwd_hit  = reg_write_mw && (write_reg_mw != 4'd0) && (write_reg_mw == rt_xm);
  assign fwd_data = fwd_hit ? wb_data : reg2_xm;

  assign wb_data = pcs_mw        ? next_pc_mw   :
                   mem_to_reg_mw ? read_data_mw :
                                   alu_out_mw;

  assign mem.mem_req   = (state_q == ACCESS);
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mem_op) state_d = ACCESS;
      ACCESS:  if (mem.mem_ack) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall      = 1'b0;
    latch_req  = 1'b0;
    capture_mw = 1'b0;
    bubble_mw  = 1'b0;
    take_load  = 1'b0;
    retire_mem = 1'b0;
    case (state_q)
      IDLE: begin
        stall      = mem_op;
        latch_req  = mem_op;
        capture_mw = ~mem_op;
        bubble_mw  = mem_op;
      end
      ACCESS: begin
        stall     = 1'b1;
        bubble_mw = 1'b1;
        take_load = mem.mem_ack & ~we_q;
      end
      DONE: begin
        capture_mw = 1'b1;
        retire_mem = 1'b1;
      end
      default: ;
    endcase
  end

  // Forwarding is resolved once, when the request is latched; the MW bubbles
  // that follow cannot disturb the store data already on the bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      load_buf_q    <= '0;
      reg_write_mw  <= 1'b0;
      mem_to_reg_mw <= 1'b0;
      pcs_mw        <= 1'b0;
      hlt_mw        <= 1'b0;
      write_reg_mw  <= '0;
      alu_out_mw    <= '0;
      read_data_mw  <= '0;
      next_pc_mw    <= '0;
    end else begin
      if (latch_req) begin
        addr_q  <= alu_out_xm;
        wdata_q <= fwd_data;
        we_q    <= mem_write_xm;
      end
      if (take_load) begin
        load_buf_q <= mem.mem_rdata;
      end
      if (capture_mw) begin
        reg_write_mw  <= reg_write_xm;
        mem_to_reg_mw <= mem_to_reg_xm;
        pcs_mw        <= pcs_xm;
        hlt_mw        <= hlt_xm;
        write_reg_mw  <= write_reg_xm;
        alu_out_mw    <= alu_out_xm;
        next_pc_mw    <= next_pc_xm;
      end else if (bubble_mw) begin
        reg_write_mw  <= 1'b0;
        mem_to_reg_mw <= 1'b0;
        pcs_mw        <= 1'b0;
        hlt_mw        <= 1'b0;
      end
      if (retire_mem) begin
        read_data_mw <= we_q ? 16'd0 : load_buf_q;
      end
    end
  end

endmodule

// File: tb/tb_memory_stage_unit.sv
module tb_memory_stage_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        mem_read_xm, mem_write_xm, mem_to_reg_xm, reg_write_xm, pcs_xm, hlt_xm;
  logic [3:0]  write_reg_xm, rt_xm;
  logic [15:0] alu_out_xm, reg2_xm, next_pc_xm;
  logic        stall, reg_write_mw, mem_to_reg_mw, pcs_mw, hlt_mw;
  logic [3:0]  write_reg_mw;
  logic [15:0] alu_out_mw, read_data_mw, next_pc_mw, wb_data;

  memory_stage_unit_if mem_bus ();

  memory_stage_unit dut (
    .clk           (clk),
    .rst           (rst),
    .mem_read_xm   (mem_read_xm),
    .mem_write_xm  (mem_write_xm),
    .mem_to_reg_xm (mem_to_reg_xm),
    .reg_write_xm  (reg_write_xm),
    .pcs_xm        (pcs_xm),
    .hlt_xm        (hlt_xm),
    .write_reg_xm  (write_reg_xm),
    .rt_xm         (rt_xm),
    .alu_out_xm    (alu_out_xm),
    .reg2_xm       (reg2_xm),
    .next_pc_xm    (next_pc_xm),
    .mem           (mem_bus),
    .stall         (stall),
    .reg_write_mw  (reg_write_mw),
    .mem_to_reg_mw (mem_to_reg_mw),
    .pcs_mw        (pcs_mw),
    .hlt_mw        (hlt_mw),
    .write_reg_mw  (write_reg_mw),
    .alu_out_mw    (alu_out_mw),
    .read_data_mw  (read_data_mw),
    .next_pc_mw    (next_pc_mw),
    .wb_data       (wb_data)
  );

  typedef struct {
    logic        rd, wr, m2r, rw, pcs, hlt;
    logic [3:0]  wreg, rt;
    logic [15:0] alu, r2, npc;
  } op_t;

  // Architectural view of the MW register after each retired instruction.
  logic        m_rw, m_m2r, m_pcs, m_hlt;
  logic [3:0]  m_wreg;
  logic [15:0] m_alu, m_rd, m_npc;

  int n_checks = 0;
  int n_fail   = 0;

  int          o_cycles, o_stalls, o_reqs;
  logic        o_bad, o_timeout, o_we;
  logic [15:0] o_addr, o_wdata;

  logic [55:0] dut_mw;
  assign dut_mw = {reg_write_mw, mem_to_reg_mw, pcs_mw, hlt_mw, write_reg_mw,
                   alu_out_mw, read_data_mw, next_pc_mw};

  function automatic logic [55:0] model_mw();
    return {m_rw, m_m2r, m_pcs, m_hlt, m_wreg, m_alu, m_rd, m_npc};
  endfunction

  function automatic logic [15:0] model_wb();
    if (m_pcs) return m_npc;
    if (m_m2r) return m_rd;
    return m_alu;
  endfunction

  function automatic logic [15:0] model_fwd(input op_t op);
    if (m_rw && m_wreg != 4'd0 && m_wreg == op.rt) return model_wb();
    return op.r2;
  endfunction

  task automatic model_reset();
    m_rw = 0; m_m2r = 0; m_pcs = 0; m_hlt = 0;
    m_wreg = 0; m_alu = 0; m_rd = 0; m_npc = 0;
  endtask

  task automatic model_retire(input op_t op, input logic [15:0] ld);
    m_rw = op.rw; m_m2r = op.m2r; m_pcs = op.pcs; m_hlt = op.hlt;
    m_wreg = op.wreg; m_alu = op.alu; m_npc = op.npc;
    if (op.rd | op.wr) m_rd = op.wr ? 16'd0 : ld;
  endtask

  function automatic op_t nop_op();
    op_t op;
    op.rd = 0; op.wr = 0; op.m2r = 0; op.rw = 0; op.pcs = 0; op.hlt = 0;
    op.wreg = 0; op.rt = 0; op.alu = 0; op.r2 = 0; op.npc = 0;
    return op;
  endfunction

  task automatic drive_op(input op_t op);
    mem_read_xm = op.rd; mem_write_xm = op.wr; mem_to_reg_xm = op.m2r;
    reg_write_xm = op.rw; pcs_xm = op.pcs; hlt_xm = op.hlt;
    write_reg_xm = op.wreg; rt_xm = op.rt;
    alu_out_xm = op.alu; reg2_xm = op.r2; next_pc_xm = op.npc;
  endtask

  // Called just after a rising edge with the DUT idle. Presents op, plays the
  // memory with an ack k cycles after the first request cycle, and returns
  // just after the edge that retires op into MW.
  task automatic run_op(input op_t op, input int k, input logic [15:0] ld);
    logic is_mem, done;
    int n;
    drive_op(op);
    mem_bus.mem_ack = 1'b0;
    mem_bus.mem_rdata = 16'($urandom);
    is_mem = op.rd | op.wr;
    o_cycles = 0; o_stalls = 0; o_reqs = 0; o_bad = 0; o_timeout = 0;
    o_addr = 0; o_wdata = 0; o_we = 0;
    @(negedge clk);
    o_cycles++; if (stall) o_stalls++; if (mem_bus.mem_req) o_bad = 1;
    @(posedge clk); #1;
    if (is_mem) begin
      n = 0; done = 0;
      while (!done && n < 64) begin
        mem_bus.mem_ack   = (n == k);
        mem_bus.mem_rdata = (n == k) ? ld : 16'($urandom);
        @(negedge clk);
        o_cycles++; if (stall) o_stalls++;
        if (!mem_bus.mem_req) o_bad = 1;
        else begin
          if (o_reqs == 0) begin
            o_addr = mem_bus.mem_addr; o_wdata = mem_bus.mem_wdata; o_we = mem_bus.mem_we;
          end else if (o_addr !== mem_bus.mem_addr || o_wdata !== mem_bus.mem_wdata ||
                       o_we !== mem_bus.mem_we) o_bad = 1;
          o_reqs++;
        end
        if (n == k) done = 1;
        n++;
        @(posedge clk); #1;
      end
      mem_bus.mem_ack = 1'b0;
      if (!done) o_timeout = 1;
      @(negedge clk);
      o_cycles++; if (stall) o_stalls++; if (mem_bus.mem_req) o_bad = 1;
      @(posedge clk); #1;
    end
    model_retire(op, ld);
    drive_op(nop_op());
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_op(nop_op());
    mem_bus.mem_ack = 1'b0;
    mem_bus.mem_rdata = 16'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (dut_mw !== 56'd0) begin n_fail++; $display("FAIL reset_mw: got %h expected 0", dut_mw); end
    n_checks++; if (wb_data !== 16'd0) begin n_fail++; $display("FAIL reset_wb: got %h expected 0", wb_data); end
    n_checks++; if ({mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_addr, mem_bus.mem_wdata} !== 34'd0) begin
      n_fail++; $display("FAIL reset_bus: got req=%b we=%b addr=%h wdata=%h expected all 0",
                         mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_addr, mem_bus.mem_wdata); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall_nop: got %b expected 0", stall); end
    mem_read_xm = 1'b1; #1;
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL reset_stall_memop: got %b expected 1", stall); end
    mem_read_xm = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_alu_op();
    op_t op;
    op = nop_op(); op.alu = 16'h1234; op.rw = 1; op.wreg = 4'd5;
    run_op(op, 0, 16'h0);
    n_checks++; if (o_stalls != 0 || o_cycles != 1) begin n_fail++; $display("FAIL alu_latency: got stalls=%0d cycles=%0d expected 0/1", o_stalls, o_cycles); end
    n_checks++; if (alu_out_mw !== 16'h1234) begin n_fail++; $display("FAIL alu_out_mw: got %h expected 1234", alu_out_mw); end
    n_checks++; if (write_reg_mw !== 4'd5) begin n_fail++; $display("FAIL alu_write_reg: got %h expected 5", write_reg_mw); end
    n_checks++; if (wb_data !== 16'h1234) begin n_fail++; $display("FAIL alu_wb: got %h expected 1234", wb_data); end
  endtask

  task automatic test_load();
    op_t op;
    op = nop_op(); op.rd = 1; op.m2r = 1; op.rw = 1; op.wreg = 4'd7; op.alu = 16'h0040;
    run_op(op, 2, 16'hBEEF);
    n_checks++; if (o_stalls != 4 || o_cycles != 5) begin n_fail++; $display("FAIL load_latency: got stalls=%0d cycles=%0d expected 4/5", o_stalls, o_cycles); end
    n_checks++; if (o_bad !== 1'b0 || o_timeout !== 1'b0 || o_reqs != 3) begin n_fail++; $display("FAIL load_handshake: got bad=%b timeout=%b reqs=%0d expected 0/0/3", o_bad, o_timeout, o_reqs); end
    n_checks++; if (o_addr !== 16'h0040 || o_we !== 1'b0) begin n_fail++; $display("FAIL load_addr_we: got %h/%b expected 0040/0", o_addr, o_we); end
    n_checks++; if (read_data_mw !== 16'hBEEF || mem_to_reg_mw !== 1'b1) begin n_fail++; $display("FAIL load_read_data: got %h m2r=%b expected beef/1", read_data_mw, mem_to_reg_mw); end
    n_checks++; if (wb_data !== 16'hBEEF) begin n_fail++; $display("FAIL load_wb: got %h expected beef", wb_data); end
  endtask

  task automatic test_store_fwd();
    op_t op;
    op = nop_op(); op.rw = 1; op.wreg = 4'd3; op.alu = 16'h00AA;
    run_op(op, 0, 16'h0);
    op = nop_op(); op.wr = 1; op.rt = 4'd3; op.r2 = 16'h1111; op.alu = 16'h0200;
    run_op(op, 1, 16'h0);
    n_checks++; if (o_wdata !== 16'h00AA || o_we !== 1'b1) begin n_fail++; $display("FAIL store_fwd: got wdata=%h we=%b expected 00aa/1", o_wdata, o_we); end
    n_checks++; if (read_data_mw !== 16'h0 || dut_mw !== model_mw()) begin n_fail++; $display("FAIL store_retire: got %h expected %h", dut_mw, model_mw()); end
    op = nop_op(); op.rw = 1; op.wreg = 4'd0; op.alu = 16'h00AA;
    run_op(op, 0, 16'h0);
    op = nop_op(); op.wr = 1; op.rt = 4'd0; op.r2 = 16'h1111; op.alu = 16'h0202;
    run_op(op, 0, 16'h0);
    n_checks++; if (o_wdata !== 16'h1111 || o_we !== 1'b1) begin n_fail++; $display("FAIL store_r0_nofwd: got wdata=%h we=%b expected 1111/1", o_wdata, o_we); end
  endtask

  task automatic test_reset_in_access();
    op_t op;
    op = nop_op(); op.rd = 1; op.m2r = 1; op.rw = 1; op.wreg = 4'd9; op.alu = 16'h0300;
    drive_op(op);
    mem_bus.mem_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (mem_bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL rst_access_req_before: got %b expected 1", mem_bus.mem_req); end
    @(posedge clk); #1;
    rst = 1'b0;
    drive_op(nop_op());
    mem_bus.mem_ack = 1'b1;
    mem_bus.mem_rdata = 16'hDEAD;
    model_reset();
    @(negedge clk);
    n_checks++; if (mem_bus.mem_req !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL rst_access_req_after: got req=%b stall=%b expected 0/0", mem_bus.mem_req, stall); end
    n_checks++; if (dut_mw !== 56'd0) begin n_fail++; $display("FAIL rst_access_mw: got %h expected 0", dut_mw); end
    @(posedge clk); #1;
    mem_bus.mem_ack = 1'b0;
    @(negedge clk);
    n_checks++; if (mem_bus.mem_req !== 1'b0 || dut_mw !== 56'd0) begin n_fail++; $display("FAIL rst_access_ack_ignored: got req=%b mw=%h expected 0/0", mem_bus.mem_req, dut_mw); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    op_t a, b;
    logic [15:0] lda, ldb, addr_a;
    lda = 16'($urandom); ldb = 16'($urandom);
    a = nop_op(); a.rd = 1; a.m2r = 1; a.rw = 1; a.wreg = 4'd1; a.alu = 16'h0010;
    b = nop_op(); b.rd = 1; b.m2r = 1; b.rw = 1; b.wreg = 4'd2; b.alu = 16'h0020;
    run_op(a, 0, lda);
    addr_a = o_addr;
    n_checks++; if (o_cycles != 3 || o_reqs != 1 || o_bad !== 1'b0) begin n_fail++; $display("FAIL b2b_a_timing: got cycles=%0d reqs=%0d bad=%b expected 3/1/0", o_cycles, o_reqs, o_bad); end
    n_checks++; if (read_data_mw !== lda || write_reg_mw !== 4'd1) begin n_fail++; $display("FAIL b2b_a_data: got %h/%h expected %h/1", read_data_mw, write_reg_mw, lda); end
    run_op(b, 0, ldb);
    n_checks++; if (o_cycles != 3 || o_reqs != 1 || o_bad !== 1'b0) begin n_fail++; $display("FAIL b2b_b_timing: got cycles=%0d reqs=%0d bad=%b expected 3/1/0", o_cycles, o_reqs, o_bad); end
    n_checks++; if (addr_a !== 16'h0010 || o_addr !== 16'h0020) begin n_fail++; $display("FAIL b2b_addrs: got %h,%h expected 0010,0020", addr_a, o_addr); end
    n_checks++; if (read_data_mw !== ldb || write_reg_mw !== 4'd2) begin n_fail++; $display("FAIL b2b_b_data: got %h/%h expected %h/2", read_data_mw, write_reg_mw, ldb); end
  endtask

  task automatic test_pcs();
    op_t op;
    op = nop_op(); op.pcs = 1; op.rw = 1; op.wreg = 4'd15; op.npc = 16'h0102; op.alu = 16'($urandom);
    drive_op(op);
    mem_bus.mem_ack = 1'b1;
    mem_bus.mem_rdata = 16'($urandom);
    @(negedge clk);
    n_checks++; if (stall !== 1'b0 || mem_bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL pcs_idle_ack: got stall=%b req=%b expected 0/0", stall, mem_bus.mem_req); end
    @(posedge clk); #1;
    mem_bus.mem_ack = 1'b0;
    model_retire(op, 16'h0);
    drive_op(nop_op());
    n_checks++; if (wb_data !== 16'h0102) begin n_fail++; $display("FAIL pcs_wb: got %h expected 0102", wb_data); end
    n_checks++; if (dut_mw !== model_mw()) begin n_fail++; $display("FAIL pcs_mw: got %h expected %h", dut_mw, model_mw()); end
  endtask

  task automatic test_random();
    op_t op;
    int k;
    logic [15:0] ld, exp_wdata;
    for (int i = 0; i < 40; i++) begin
      op.rd = ($urandom_range(0, 2) == 0); op.wr = ($urandom_range(0, 2) == 0);
      op.m2r = 1'($urandom); op.rw = 1'($urandom); op.pcs = ($urandom_range(0, 4) == 0);
      op.hlt = ($urandom_range(0, 7) == 0);
      op.wreg = 4'($urandom_range(0, 3)); op.rt = 4'($urandom_range(0, 3));
      op.alu = 16'($urandom); op.r2 = 16'($urandom); op.npc = 16'($urandom);
      k = $urandom_range(0, 4);
      ld = 16'($urandom);
      exp_wdata = model_fwd(op);
      run_op(op, k, ld);
      if (op.rd | op.wr) begin
        n_checks++; if (o_stalls != k + 2 || o_cycles != k + 3 || o_bad !== 1'b0 || o_timeout !== 1'b0) begin
          n_fail++; $display("FAIL rand_mem_timing[%0d]: got stalls=%0d cycles=%0d bad=%b to=%b expected %0d/%0d/0/0",
                             i, o_stalls, o_cycles, o_bad, o_timeout, k + 2, k + 3); end
        n_checks++; if (o_addr !== op.alu || o_we !== op.wr || o_wdata !== exp_wdata) begin
          n_fail++; $display("FAIL rand_mem_bus[%0d]: got %h/%b/%h expected %h/%b/%h",
                             i, o_addr, o_we, o_wdata, op.alu, op.wr, exp_wdata); end
      end else begin
        n_checks++; if (o_stalls != 0 || o_cycles != 1 || o_bad !== 1'b0) begin
          n_fail++; $display("FAIL rand_alu_timing[%0d]: got stalls=%0d cycles=%0d bad=%b expected 0/1/0", i, o_stalls, o_cycles, o_bad); end
      end
      n_checks++; if (dut_mw !== model_mw()) begin n_fail++; $display("FAIL rand_mw[%0d]: got %h expected %h", i, dut_mw, model_mw()); end
      n_checks++; if (wb_data !== model_wb()) begin n_fail++; $display("FAIL rand_wb[%0d]: got %h expected %h", i, wb_data, model_wb()); end
    end
  endtask

  initial begin
    test_reset();
    test_alu_op();
    test_load();
    test_store_fwd();
    test_reset_in_access();
    test_back_to_back();
    test_pcs();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
